nibble_serial_subtractor: RTL and testbench

//  Multi-cycle subtractor computing Diff = inA - inB - Bin, one 4-bit nibble per cycle (LSB first).

---
 rtl/nibble_serial_subtractor.sv | 120 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: Diff = inA - inB - Bin, one 4-bit nibble per cycle, LSB first.
// Borrow ripples between nibbles through a register. Results hold until the next completion.
module nibble_serial_subtractor #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Zero,
   output logic             Ofl,
   output logic [1:0]       o_dbg_state
);

   localparam int NIB   = WIDTH / 4;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_work;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_brw;
   logic               w_accept;
   logic               w_last;
   logic [3:0]         w_a_nib;
   logic [3:0]         w_b_nib;
   logic [4:0]         w_sub;
   logic [WIDTH-1:0]   w_work_next;

   // A request is only honoured when no operation is in flight.
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_cnt == CNT_W'(NIB - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy        = (r_state == S_RUN);
      done        = (r_state == S_DONE);
      o_dbg_state = r_state;
   end

   // Nibble select and 5-bit borrow-aware subtract; bit 4 is the borrow out.
   always_comb begin
      w_a_nib     = '0;
      w_b_nib     = '0;
      for (int i = 0; i < NIB; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_a_nib = r_a[4*i +: 4];
            w_b_nib = r_b[4*i +: 4];
         end
      end
      w_sub       = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_brw};
      w_work_next = r_work;
      for (int i = 0; i < NIB; i++) begin
         if (r_cnt == CNT_W'(i)) begin
            w_work_next[4*i +: 4] = w_sub[3:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_work <= '0;
         r_cnt  <= '0;
         r_brw  <= 1'b0;
         Diff   <= '0;
         Bout   <= 1'b0;
         Zero   <= 1'b0;
         Ofl    <= 1'b0;
      end else if (w_accept) begin
         r_a   <= inA;
         r_b   <= inB;
         r_cnt <= '0;
         r_brw <= Bin;
      end else if (r_state == S_RUN) begin
         r_work <= w_work_next;
         r_brw  <= w_sub[4];
         r_cnt  <= r_cnt + CNT_W'(1);
         if (w_last) begin
            Diff <= w_work_next;
            Bout <= w_sub[4];
            Zero <= (w_work_next == '0);
            Ofl  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_work_next[WIDTH-1] != r_a[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Bench for nibble_serial_subtractor: cycle-level arithmetic model compared every cycle,
// plus directed operations with hand-computed results.
module tb_nibble_serial_subtractor;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] inA;
   logic [W-1:0] inB;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;
   logic         Zero;
   logic         Ofl;
   logic [1:0]   o_dbg_state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   nibble_serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inA(inA), .inB(inB), .Bin(Bin),
      .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .Zero(Zero), .Ofl(Ofl),
      .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   // Model: cycles-remaining countdown and arithmetic results from plain integers.
   int           m_left;
   bit           m_done;
   logic [W-1:0] m_diff, p_diff;
   bit           m_bout, m_zero, m_ofl, p_bout, p_zero, p_ofl;

   task automatic calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output logic [W-1:0] d, output bit bo, output bit z, output bit o);
      longint ua, ub, sa, sb, sr;
      ua = longint'(a);
      ub = longint'(b);
      sa = (a[W-1]) ? ua - (longint'(1) << W) : ua;
      sb = (b[W-1]) ? ub - (longint'(1) << W) : ub;
      sr = sa - sb - longint'(bi);
      d  = W'(ua - ub - longint'(bi));
      bo = (ua < ub + longint'(bi));
      z  = (d == '0);
      o  = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left = 0; m_done = 0;
         m_diff = '0; m_bout = 0; m_zero = 0; m_ofl = 0;
      end else begin
         m_done = 0;
         if (m_left != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_done = 1;
               m_diff = p_diff; m_bout = p_bout; m_zero = p_zero; m_ofl = p_ofl;
            end
         end else if (start) begin
            calc(inA, inB, Bin, p_diff, p_bout, p_zero, p_ofl);
            m_left = NIB;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy", 32'(busy), 32'(m_left != 0));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_diff", 32'(Diff), 32'(m_diff));
         check("cyc_bout", 32'(Bout), 32'(m_bout));
         check("cyc_zero", 32'(Zero), 32'(m_zero));
         check("cyc_ofl",  32'(Ofl),  32'(m_ofl));
      end
   end

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      inA = a; inB = b; Bin = bi; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      inA = W'($urandom); inB = W'($urandom); Bin = 1'($urandom);
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         errors++;
         $display("FAIL done_timeout act=0 exp=1 time=%0t", $time);
      end
   endtask

   task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic bi, input logic [W-1:0] ed, input bit eb,
                           input bit ez, input bit eo);
      int c;
      start_op(a, b, bi);
      wait_done(c);
      check({name, "_lat"},  32'(c), 32'(NIB));
      check({name, "_diff"}, 32'(Diff), 32'(ed));
      check({name, "_bout"}, 32'(Bout), 32'(eb));
      check({name, "_zero"}, 32'(Zero), 32'(ez));
      check({name, "_ofl"},  32'(Ofl),  32'(eo));
      @(negedge clk);
   endtask

   initial begin
      int c, ndone, gap;
      logic [W-1:0] ra, rb;
      logic         rbi;
      logic [W-1:0] ed;
      bit           eb, ez, eo;

      // Reset with start held high
      rst_n = 1'b0; start = 1'b1; inA = 16'h1234; inB = 16'h0001; Bin = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(Diff), 32'd0);
      check("rst_flags", 32'({Bout, Zero, Ofl}), 32'd0);
      chk_en = 1'b1;
      rst_n = 1'b1; start = 1'b0;
      @(negedge clk);

      directed("t2",  16'h1234, 16'h0034, 1'b0, 16'h1200, 0, 0, 0);
      directed("t3a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1, 0, 0);
      directed("t3b", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 0, 1);
      directed("t4a", 16'h0005, 16'h0004, 1'b1, 16'h0000, 0, 1, 0);
      directed("t4b", 16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1, 0, 0);

      // start hammered during RUN with other operands
      ndone = 0;
      start_op(16'hABCD, 16'h1234, 1'b0);
      for (int i = 0; i < NIB; i++) begin
         if (done) ndone++;
         start = 1'b1; inA = W'($urandom); inB = W'($urandom); Bin = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("t5_ndone", 32'(ndone), 32'd1);
      check("t5_diff",  32'(Diff), 32'h9999);

      // Back-to-back: second start in the DONE cycle
      start_op(16'h5000, 16'h1000, 1'b0);
      wait_done(c);
      check("t5b_diff1", 32'(Diff), 32'h4000);
      start_op(16'h0001, 16'h0002, 1'b0);
      wait_done(c);
      check("t5b_lat", 32'(c + 1), 32'(NIB + 1));
      check("t5b_diff2", 32'(Diff), 32'hFFFF);
      check("t5b_bout2", 32'(Bout), 32'd1);
      @(negedge clk);

      // Reset in the second RUN cycle
      start_op(16'h7777, 16'h1111, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_done", 32'(done), 32'd0);
      check("t6_diff", 32'(Diff), 32'd0);
      check("t6_flags", 32'({Bout, Zero, Ofl}), 32'd0);
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) ndone++;
         @(negedge clk);
      end
      check("t6_nodone", 32'(ndone), 32'd0);
      directed("t6_fresh", 16'h7777, 16'h1111, 1'b1, 16'h6665, 0, 0, 0);

      // Randomized operations, with occasional back-to-back starts
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 4))
            0: ra = 16'h0000;
            1: ra = 16'h8000;
            2: ra = 16'h7FFF;
            default: ra = W'($urandom);
         endcase
         rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         rbi = 1'($urandom);
         calc(ra, rb, rbi, ed, eb, ez, eo);
         start_op(ra, rb, rbi);
         wait_done(c);
         check("rnd_lat", 32'(c), 32'(NIB));
         check("rnd_res", 32'({Diff, Bout, Zero, Ofl}), 32'({ed, eb, ez, eo}));
         if ($urandom_range(0, 2) != 0) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
         end
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
